instr_fetch: RTL and testbench



---
 rtl/cpu_pkg.sv | 29 ++
 rtl/instr_fetch_if.sv | 17 +
 rtl/fetch_skid.sv | 48 ++++
 rtl/instr_fetch.sv | 159 +++++++++++++++
 tb/tb_instr_fetch.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg : shared fetch-stage types, widths and helpers
// Rev 1.0 : initial release
// ============================================================================
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc_plus_4;
    logic               interrupt;
  } fetch_bundle_t;

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
    return a & ~PC_W'(3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// instr_fetch_if : instruction-memory request/ready bus
// Rev 1.0 : initial release
// ============================================================================
interface instr_fetch_if import cpu_pkg::*; ();

  logic               req;
  logic [PC_W-1:0]    addr;
  logic               rdy;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, output addr, input rdy, input rdata);
  modport slave  (input req, input addr, output rdy, output rdata);

endinterface
`default_nettype wire

// File: rtl/fetch_skid.sv
`default_nettype none
// ============================================================================
// fetch_skid : one-entry holding register for a word returned under stall
// Rev 1.0 : initial release
// ============================================================================
module fetch_skid import cpu_pkg::*; (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          unload,
  input  logic          clear,
  input  fetch_bundle_t din,
  output logic          full,
  output fetch_bundle_t dout
);

  logic          full_q, full_d;
  fetch_bundle_t data_q, data_d;

  // clear (flush) dominates a same-cycle load
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d = 1'b1;
      data_d = din;
    end else if (unload) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign dout = data_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// instr_fetch : PC owner, imem handshake, branch/interrupt redirect, skid
// Rev 1.0 : initial release
// ============================================================================
module instr_fetch import cpu_pkg::*; #(
  parameter logic [PC_W-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [PC_W-1:0] IRQ_VEC   = 32'h0000_0010
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_if.master      imem,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_pc,
  input  logic               irq,
  input  logic               irq_ret,
  output logic               irq_ack,
  output logic [PC_W-1:0]    epc,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc_plus_4,
  output logic               out_interrupt
);

  fetch_state_t  state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, tgt_q, tgt_d, epc_q, epc_d;
  fetch_bundle_t out_q, out_d;
  logic irq_en_q, irq_en_d, irq_ack_q, irq_ack_d, pend_int_q, pend_int_d;

  logic          skid_full, skid_load, skid_unload, skid_clear;
  fetch_bundle_t skid_dout, fetched;
  logic          req, take, redirect, outstanding;
  logic [PC_W-1:0] redir_pc;

  fetch_skid u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (skid_load),
    .unload (skid_unload),
    .clear  (skid_clear),
    .din    (fetched),
    .full   (skid_full),
    .dout   (skid_dout)
  );

  assign req         = ((state_q == FETCH) && !skid_full) || (state_q == DRAIN);
  assign imem.req    = req;
  assign imem.addr   = word_align(pc_q);
  assign take        = irq && irq_en_q && (state_q != BOOT);
  assign redirect    = take || branch_taken;
  assign redir_pc    = take ? IRQ_VEC : word_align(branch_pc);
  assign outstanding = req && !imem.rdy;

  always_comb begin
    fetched.valid     = 1'b1;
    fetched.instr     = imem.rdata;
    fetched.pc_plus_4 = pc_q + 32'd4;
    fetched.interrupt = pend_int_q;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    out_d       = out_q;
    epc_d       = epc_q;
    irq_en_d    = irq_en_q;
    irq_ack_d   = take;
    pend_int_d  = pend_int_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;

    // bubble unless a word is delivered below; stall freezes the bundle
    if (!stall) begin
      out_d.valid = 1'b0;
    end

    if (take) begin
      epc_d    = branch_taken ? word_align(branch_pc) : pc_q;
      irq_en_d = 1'b0;
    end else if (irq_ret) begin
      irq_en_d = 1'b1;
    end

    if (redirect) begin
      out_d.valid = 1'b0;
      skid_clear  = 1'b1;
      pend_int_d  = take;
      if (outstanding) begin
        state_d = DRAIN;
        tgt_d   = redir_pc;
      end else begin
        state_d = FETCH;
        pc_d    = redir_pc;
      end
    end else begin
      case (state_q)
        BOOT: state_d = FETCH;
        FETCH: begin
          if (skid_full) begin
            if (!stall) begin
              out_d       = skid_dout;
              skid_unload = 1'b1;
            end
          end else if (imem.rdy) begin
            pc_d       = pc_q + 32'd4;
            pend_int_d = 1'b0;
            if (stall) begin
              skid_load = 1'b1;
            end else begin
              out_d = fetched;
            end
          end
        end
        DRAIN: begin
          // the stale word returning now is dropped
          if (imem.rdy) begin
            pc_d    = tgt_q;
            state_d = FETCH;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      tgt_q      <= '0;
      out_q      <= '0;
      epc_q      <= '0;
      irq_en_q   <= 1'b1;
      irq_ack_q  <= 1'b0;
      pend_int_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      out_q      <= out_d;
      epc_q      <= epc_d;
      irq_en_q   <= irq_en_d;
      irq_ack_q  <= irq_ack_d;
      pend_int_q <= pend_int_d;
    end
  end

  assign irq_ack       = irq_ack_q;
  assign epc           = epc_q;
  assign out_valid     = out_q.valid;
  assign out_instr     = out_q.instr;
  assign out_pc_plus_4 = out_q.pc_plus_4;
  assign out_interrupt = out_q.interrupt;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch : directed stimulus with a queue-based bundle scoreboard
// Rev 1.0 : initial release
// ============================================================================
module tb_instr_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy_en;
  logic        stall, branch_taken, irq, irq_ret;
  logic [31:0] branch_pc;
  logic        irq_ack, out_valid, out_interrupt;
  logic [31:0] epc, out_instr, out_pc_plus_4;

  int n_cmp = 0;
  int n_err = 0;
  fetch_bundle_t exp_q[$];

  instr_fetch_if imem ();

  instr_fetch #(.RESET_VEC(32'h0000_0000), .IRQ_VEC(32'h0000_0010)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (imem),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_pc     (branch_pc),
    .irq           (irq),
    .irq_ret       (irq_ret),
    .irq_ack       (irq_ack),
    .epc           (epc),
    .out_valid     (out_valid),
    .out_instr     (out_instr),
    .out_pc_plus_4 (out_pc_plus_4),
    .out_interrupt (out_interrupt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  always_comb begin
    imem.rdy   = rdy_en;
    imem.rdata = mem_word(imem.addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] p4, input logic intr);
    fetch_bundle_t b;
    b.valid = 1'b1; b.instr = mem_word(a); b.pc_plus_4 = p4; b.interrupt = intr;
    exp_q.push_back(b);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // monitor: a bundle is consumed when valid and not stalled
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && stall === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_bundle: got pc_plus_4=%h expected no bundle", out_pc_plus_4);
      end else begin
        fetch_bundle_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if (out_instr !== e.instr || out_pc_plus_4 !== e.pc_plus_4 || out_interrupt !== e.interrupt) begin
          n_err++;
          $display("FAIL bundle: got instr=%h pc4=%h int=%b expected instr=%h pc4=%h int=%b",
                   out_instr, out_pc_plus_4, out_interrupt, e.instr, e.pc_plus_4, e.interrupt);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; rdy_en = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    branch_pc = 32'h0; irq = 1'b0; irq_ret = 1'b0;
    repeat (2) @(posedge clk);
    at_neg();
    chk("rst_req",   {31'd0, imem.req},      32'd0);
    chk("rst_valid", {31'd0, out_valid},     32'd0);
    chk("rst_instr", out_instr,              32'd0);
    chk("rst_pc4",   out_pc_plus_4,          32'd0);
    chk("rst_int",   {31'd0, out_interrupt}, 32'd0);
    chk("rst_ack",   {31'd0, irq_ack},       32'd0);
    chk("rst_epc",   epc,                    32'd0);

    // sequential fetch after BOOT
    push(32'h0, 32'h4, 1'b0); push(32'h4, 32'h8, 1'b0); push(32'h8, 32'hC, 1'b0);
    tick(); rst_n = 1'b1;
    at_neg(); chk("boot_req", {31'd0, imem.req}, 32'd0);
    tick(); at_neg(); chk("seq_addr0", imem.addr, 32'h0); chk("seq_req", {31'd0, imem.req}, 32'd1);
    tick(); at_neg(); chk("seq_addr4", imem.addr, 32'h4);
    tick(); at_neg(); chk("seq_addr8", imem.addr, 32'h8);
    tick(); rdy_en = 1'b0;
    tick(); tick();

    // stall 3 cycles with rdy high
    push(32'hC, 32'h10, 1'b0); push(32'h10, 32'h14, 1'b0);
    push(32'h14, 32'h18, 1'b0); push(32'h18, 32'h1C, 1'b0);
    tick(); rdy_en = 1'b1;
    tick(); stall = 1'b1;
    at_neg(); chk("stall_out0", out_pc_plus_4, 32'h10);
    tick(); at_neg(); chk("stall_req1", {31'd0, imem.req}, 32'd0); chk("stall_hold1", out_pc_plus_4, 32'h10);
    tick(); at_neg(); chk("stall_req2", {31'd0, imem.req}, 32'd0); chk("stall_hold2", out_instr, mem_word(32'hC));
    tick(); stall = 1'b0;
    at_neg(); chk("unload_req", {31'd0, imem.req}, 32'd0);
    tick(); at_neg(); chk("skid_out", out_pc_plus_4, 32'h14); chk("resume_addr", imem.addr, 32'h14);
    tick(); at_neg(); chk("resume_addr2", imem.addr, 32'h18);

    // branch while a request is outstanding -> DRAIN
    tick(); rdy_en = 1'b0; branch_taken = 1'b1; branch_pc = 32'h0000_0103;
    at_neg(); chk("drain_addr0", imem.addr, 32'h1C);
    push(32'h100, 32'h104, 1'b0);
    tick(); branch_taken = 1'b0;
    at_neg(); chk("drain_addr1", imem.addr, 32'h1C); chk("drain_req", {31'd0, imem.req}, 32'd1);
    chk("drain_valid1", {31'd0, out_valid}, 32'd0);
    tick(); rdy_en = 1'b1;
    at_neg(); chk("drain_addr2", imem.addr, 32'h1C); chk("drain_valid2", {31'd0, out_valid}, 32'd0);
    tick(); at_neg(); chk("br_addr", imem.addr, 32'h100); chk("discard_valid", {31'd0, out_valid}, 32'd0);
    tick(); rdy_en = 1'b0;

    // interrupt at pc 0x40
    tick(); rdy_en = 1'b1; branch_taken = 1'b1; branch_pc = 32'h40;
    tick(); branch_taken = 1'b0; irq = 1'b1;
    at_neg(); chk("irq_pc", imem.addr, 32'h40); chk("irq_ack_pre", {31'd0, irq_ack}, 32'd0);
    push(32'h10, 32'h14, 1'b1); push(32'h14, 32'h18, 1'b0);
    tick(); at_neg(); chk("irq_ack", {31'd0, irq_ack}, 32'd1); chk("irq_epc", epc, 32'h40);
    chk("irq_vec", imem.addr, 32'h10); chk("irq_flush", {31'd0, out_valid}, 32'd0);
    tick(); at_neg(); chk("irq_ack_pulse", {31'd0, irq_ack}, 32'd0); chk("irq_first", {31'd0, out_interrupt}, 32'd1);
    tick(); rdy_en = 1'b0;
    at_neg(); chk("irq_masked", {31'd0, irq_ack}, 32'd0); chk("irq_second", {31'd0, out_interrupt}, 32'd0);
    tick(); irq = 1'b0; irq_ret = 1'b1;
    at_neg(); chk("irq_masked2", {31'd0, irq_ack}, 32'd0);

    // branch and interrupt together
    tick(); irq_ret = 1'b0; irq = 1'b1; branch_taken = 1'b1; branch_pc = 32'h200; rdy_en = 1'b1;
    push(32'h10, 32'h14, 1'b1);
    tick(); irq = 1'b0; branch_taken = 1'b0;
    at_neg(); chk("both_ack", {31'd0, irq_ack}, 32'd1); chk("both_epc", epc, 32'h200);
    chk("both_addr", imem.addr, 32'h10);
    tick(); rdy_en = 1'b0;

    // PC wrap
    tick(); rdy_en = 1'b1; branch_taken = 1'b1; branch_pc = 32'hFFFF_FFFC;
    push(32'hFFFF_FFFC, 32'h0, 1'b0); push(32'h0, 32'h4, 1'b0);
    tick(); branch_taken = 1'b0;
    at_neg(); chk("wrap_addr", imem.addr, 32'hFFFF_FFFC);
    tick(); at_neg(); chk("wrap_next", imem.addr, 32'h0); chk("wrap_pc4", out_pc_plus_4, 32'h0);
    chk("wrap_valid", {31'd0, out_valid}, 32'd1);
    tick(); rdy_en = 1'b0;
    repeat (3) tick();
    at_neg(); chk("queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
